// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared encodings and default sizing for the MAC array accumulator
package mac_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE0 = 2'b00,
    MODE_INT8  = 2'b01,
    MODE_INT4  = 2'b10,
    MODE_IDLE3 = 2'b11
  } mode_e;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam int DEF_ROWS     = 16;
  localparam int DEF_N_ELEM   = 32;
  localparam int DEF_COLS     = 16;
  localparam int DEF_ACC_W    = 24;
  localparam int DEF_SATURATE = 1;

endpackage

// File: rtl/mac_array_acc_if.sv
// rtl/mac_array_acc_if.sv - beat input, tile output and control bundle of the MAC array
interface mac_array_acc_if #(
  parameter int ROWS   = mac_pkg::DEF_ROWS,
  parameter int N_ELEM = mac_pkg::DEF_N_ELEM,
  parameter int COLS   = mac_pkg::DEF_COLS,
  parameter int ACC_W  = mac_pkg::DEF_ACC_W
);
  logic                        flush;
  logic [1:0]                  mode;
  logic [4:0]                  acc_len;
  logic                        in_valid;
  logic                        in_ready;
  logic [ROWS*N_ELEM*8-1:0]    a_vec;
  logic [N_ELEM*8-1:0]         b_vec;
  logic                        out_valid;
  logic                        out_ready;
  logic [ROWS*COLS*ACC_W-1:0]  tile_out;
  logic [$clog2(COLS)-1:0]     col_idx;

  modport master (
    output flush, mode, acc_len, in_valid, a_vec, b_vec, out_ready,
    input  in_ready, out_valid, tile_out, col_idx
  );

  modport slave (
    input  flush, mode, acc_len, in_valid, a_vec, b_vec, out_ready,
    output in_ready, out_valid, tile_out, col_idx
  );
endinterface

// File: rtl/mac_row_dot.sv
// rtl/mac_row_dot.sv - combinational signed int8 / int4 dot product for one row lane
module mac_row_dot
  import mac_pkg::*;
#(
  parameter int N_ELEM = DEF_N_ELEM,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  mode_e                   mode,
  input  logic [N_ELEM*8-1:0]     a,
  input  logic [N_ELEM*8-1:0]     b,
  output logic [ACC_W-1:0]        dot
);
  // one guard bit above the worst case N_ELEM * (-128 * -128)
  localparam int DOT_W = 17 + $clog2(N_ELEM);

  logic signed [DOT_W-1:0] sum;
  logic signed [7:0]       ab, bb;
  logic signed [3:0]       al, ah, bl, bh;

  always_comb begin
    sum = '0;
    ab  = '0;
    bb  = '0;
    al  = '0;
    ah  = '0;
    bl  = '0;
    bh  = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      ab = a[i*8 +: 8];
      bb = b[i*8 +: 8];
      al = ab[3:0];
      ah = ab[7:4];
      bl = bb[3:0];
      bh = bb[7:4];
      case (mode)
        MODE_INT8: sum = sum + DOT_W'(16'(ab) * 16'(bb));
        MODE_INT4: sum = sum + DOT_W'(8'(al) * 8'(bl)) + DOT_W'(8'(ah) * 8'(bh));
        default: ;
      endcase
    end
  end

  assign dot = ACC_W'(sum);

endmodule

// File: rtl/mac_array_acc.sv
// rtl/mac_array_acc.sv - ROWS-lane MAC array filling a COLS-column result tile per handshake
module mac_array_acc
  import mac_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int N_ELEM   = DEF_N_ELEM,
  parameter int COLS     = DEF_COLS,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int SATURATE = DEF_SATURATE
) (
  input  logic            clk,
  input  logic            rst_n,
  mac_array_acc_if.slave  bus
);
  localparam int CW = $clog2(COLS);

  state_e                         state_q, state_d;
  mode_e                          mode_q, eff_mode;
  logic [4:0]                     len_q, eff_len;
  logic [4:0]                     k_q;
  logic [CW-1:0]                  col_q;
  logic [ROWS-1:0][ACC_W-1:0]     acc_q;
  logic [ROWS-1:0][ACC_W-1:0]     dot;
  logic [ROWS-1:0][ACC_W-1:0]     sum;
  logic [ROWS*COLS*ACC_W-1:0]     tile_q;
  logic                           accept, first_beat, last_beat, last_col;

  assign bus.in_ready  = (state_q == ST_ACCUM);
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.tile_out  = tile_q;
  assign bus.col_idx   = col_q;

  // the first beat of a tile uses live mode/acc_len; later beats use the captured copy
  assign accept     = bus.in_valid && bus.in_ready && !bus.flush;
  assign first_beat = (k_q == '0) && (col_q == '0);
  assign eff_mode   = first_beat ? mode_e'(bus.mode) : mode_q;
  assign eff_len    = first_beat ? bus.acc_len : len_q;
  assign last_beat  = (eff_len == 5'd0) || (k_q == eff_len - 5'd1);
  assign last_col   = (col_q == CW'(COLS - 1));

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    mac_row_dot #(.N_ELEM(N_ELEM), .ACC_W(ACC_W)) u_dot (
      .mode (eff_mode),
      .a    (bus.a_vec[r*N_ELEM*8 +: N_ELEM*8]),
      .b    (bus.b_vec),
      .dot  (dot[r])
    );

    if (SATURATE != 0) begin : g_sat
      logic [ACC_W:0] wide;
      assign wide   = {acc_q[r][ACC_W-1], acc_q[r]} + {dot[r][ACC_W-1], dot[r]};
      assign sum[r] = (wide[ACC_W] == wide[ACC_W-1]) ? wide[ACC_W-1:0] :
                      wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin : g_wrap
      assign sum[r] = acc_q[r] + dot[r];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = ST_ACCUM;
    end else begin
      case (state_q)
        ST_ACCUM: if (accept && last_beat && last_col) state_d = ST_FULL;
        ST_FULL:  if (bus.out_ready) state_d = ST_ACCUM;
        default:  state_d = ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q    <= '0;
      col_q  <= '0;
      acc_q  <= '0;
      tile_q <= '0;
      mode_q <= MODE_IDLE0;
      len_q  <= 5'd1;
    end else if (bus.flush) begin
      k_q   <= '0;
      col_q <= '0;
      acc_q <= '0;
    end else if (accept) begin
      if (first_beat) begin
        mode_q <= eff_mode;
        len_q  <= eff_len;
      end
      if (last_beat) begin
        for (int r = 0; r < ROWS; r++) begin
          tile_q[(r*COLS + int'(col_q))*ACC_W +: ACC_W] <= sum[r];
        end
        acc_q <= '0;
        k_q   <= '0;
        col_q <= last_col ? '0 : col_q + 1'b1;
      end else begin
        acc_q <= sum;
        k_q   <= k_q + 5'd1;
      end
    end
  end

endmodule

// File: doc/mac_array_acc.md
MAC_ARRAY_ACC -- requirements
Module: mac_array_acc

Interface
REQ-001 SHALL have parameter ROWS, default 16, number of row MAC lanes.
REQ-002 SHALL have parameter N_ELEM, default 32, bytes per operand vector.
REQ-003 SHALL have parameter COLS, default 16, result columns per tile.
REQ-004 SHALL have parameter ACC_W, default 24, signed accumulator/result width.
REQ-005 SHALL have parameter SATURATE, default 1; 1 = saturating accumulate, 0 = two's-complement wrap.
REQ-006 clk  input  1  single clock, rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 flush  input  1  synchronous tile abort.
REQ-009 mode  input  2  01 int8, 10 int4, 00/11 idle (zero product).
REQ-010 acc_len  input  5  beats accumulated per column, 0 treated as 1.
REQ-011 in_valid  input  1  beat valid.
REQ-012 in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-013 a_vec  input  ROWS*N_ELEM*8  row r operand at [r*N_ELEM*8 +: N_ELEM*8].
REQ-014 b_vec  input  N_ELEM*8  operand broadcast to all rows.
REQ-015 out_valid  output  1  tile complete.
REQ-016 out_ready  input  1  tile consumed when out_valid && out_ready.
REQ-017 tile_out  output  ROWS*COLS*ACC_W  row r, column c at [(r*COLS+c)*ACC_W +: ACC_W].
REQ-018 col_idx  output  $clog2(COLS)  column currently accumulating.

Function
REQ-019 int8 dot SHALL be the sum of N_ELEM signed byte products a[i]*b[i]; int4 dot SHALL be the sum of 2*N_ELEM signed nibble products, low nibble with low, high with high.
REQ-020 Dot SHALL be sign-extended to ACC_W; acc+dot SHALL clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1] when SATURATE=1, else wrap.
REQ-021 States: ACCUM, FULL; in_ready=1 in ACCUM, 0 in FULL; out_valid=1 only in FULL.
REQ-022 mode and acc_len SHALL be captured on the first accepted beat of each tile; mid-tile changes ignored.
REQ-023 Each accepted beat SHALL add dot to row accumulators and increment beat counter k.
REQ-024 On the beat with k==acc_len-1: tile_out[r][col_idx] <= acc+dot (registered, visible next cycle), accumulators and k cleared, col_idx incremented.
REQ-025 On the last beat of column COLS-1: col_idx wraps to 0, state -> FULL next cycle.
REQ-026 In FULL, tile_out SHALL hold stable; on out_ready, state -> ACCUM next cycle, tile_out retained until overwritten.
REQ-027 flush SHALL have priority over any accept/consume: clears k, col_idx, accumulators, state -> ACCUM, out_valid low next cycle; tile_out unchanged.
REQ-028 No beat SHALL be accepted in the cycle out_valid is dropping; accept resumes the cycle after return to ACCUM.

Reset
REQ-029 On rst_n low: state ACCUM, k=0, col_idx=0, accumulators 0, tile_out 0, out_valid 0, in_ready 1 after release; captured mode 00, acc_len 1.
REQ-030 Reset mid-tile SHALL discard all partial results with no output handshake.

Structure
REQ-031 Mode encodings, state encoding and default parameter values SHALL live in shared package mac_pkg.
REQ-032 One sub-module mac_row_dot (one row: int8/int4 dot product, combinational) SHALL be instantiated ROWS times via generate.

Verification
REQ-033 int8, acc_len=1, all a bytes=1, b bytes=2, 16 beats -> out_valid after 16th beat, every tile_out entry = 64.
REQ-034 int4, acc_len=2, a nibbles=-1 (0xFF), b nibbles=3 (0x33) -> each column = 2*64*(-3) = -384.
REQ-035 int8, acc_len=31, a=b=127 all bytes, SATURATE=1 -> each entry = 8388607; SATURATE=0 -> wrapped value (31*32*16129) mod 2^24 as signed.
REQ-036 Tile full with out_ready=0 for 10 cycles while in_valid=1 -> in_ready=0, tile_out stable, no beat lost; out_ready pulse -> next tile starts at col_idx 0.
REQ-037 flush asserted after column 5 beat 0 -> col_idx=0, out_valid=0 next cycle; next full tile matches fresh computation.
REQ-038 rst_n pulsed low mid-tile -> all outputs reset values, in_ready=1 after release.
